seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Board-level output stage directly downstream of the CPU top.
- Consumes the 32-bit value the CPU selects for display (syscall output, memory word, PC, cycle counters) and drives eight multiplexed common-anode seven-segment digits.
- Time-multiplexes the digits with a prescaled scan tick and shows each nibble as a hex glyph.
- Latches the input value once per frame, so a value changing mid-scan never shows torn digits.
- Supports leading-zero blanking and per-digit decimal points.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit, 125 Hz frame); legal range 2..2^20.
- NUM_DIGITS, 8, digits scanned; the block is fixed at 8, and the parameter exists for the assertion only.

Ports:
- clk  in  1  system clock (undivided board clock)
- in_RST  in  1  asynchronous, active-low reset
- data  in  32  value to display; digit i shows data[4i+3:4i]
- blank_lz  in  1  1 = suppress leading zero digits
- dp  in  8  decimal point request per digit, active-high; sampled with data
- SEG  out  8  cathodes, active-low; bit0=a .. bit6=g, bit7=DP
- AN  out  8  anodes, active-low one-hot; AN[i] enables digit i
- frame_done  out  1  one-cycle pulse when a new snapshot is latched

Behaviour:
- Reset (in_RST=0, async): prescaler=0, idx=0, snapshot data=0, snapshot dp=0, AN=8'hFF, SEG=8'hFF, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 in the cycle where the count equals SCAN_DIV-1.
- Digit index idx (3 bits):
  - Increments on tick; 7 wraps to 0.
  - When tick and idx==7: data and dp are latched into the snapshot, and frame_done=1 in the next cycle.
- Outputs are registered:
  - In the cycle after a tick, AN = ~(1<<idx_new) and SEG = glyph of snapshot nibble idx_new.
  - The snapshot used is the one already valid at that edge. A snapshot latched on the same edge takes effect from digit 0 of this frame, because the snapshot update and the digit-0 output register update in the same cycle: the decode path reads the next snapshot value.
  - Between ticks, AN and SEG hold.
- First visible output: digit 1 after the first tick following reset (idx 0->1). Digit 0 first appears after 8 ticks.
- Glyphs (active-low, bits 6..0), nibble 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- SEG[7] = ~dp_snap[idx].
- Leading-zero blanking:
  - Condition: blank_lz=1 (sampled live, not snapshotted), idx!=0, and every snapshot nibble at index >= idx is 0.
  - Effect: SEG=8'hFF while AN still selects the digit, so the scan timing stays uniform.
  - Digit 0 is never blanked, so 0 displays as "0".
  - The DP of a blanked digit is also suppressed.
- Simultaneous events:
  - A data change in the latch cycle is captured: the value present at that edge is the one latched.
  - A blank_lz change takes effect at the next tick.
- Reset mid-frame returns to the reset state immediately; the display is dark until the next tick.

Decomposition:
- Shared package seg7_pkg:
  - Glyph constant table (16 x 7 bits).
  - SEG_OFF=8'hFF and AN_OFF=8'hFF localparams.
  - Function hex_glyph(nibble).
- One sub-module is natural: seg7_hex_decoder (combinational nibble+dp+blank -> SEG), reused by other board front panels.
- Prescaler, index, snapshot and blanking logic stay in the top.

Test Plan (SCAN_DIV=4):
- Reset, release, data=32'h0000_00A5, blank_lz=0 -> AN=FF/SEG=FF until the first tick. After that, every 4 clk AN steps FD,FB,F7,...,7F,FE. At AN=FE SEG=92 ('5'); at AN=FD SEG=88 ('A'); higher digits C0.
- data=32'h0000_00A5, blank_lz=1 -> over a full frame, slots 2..7 give SEG=FF; slot 0 SEG=92, slot 1 SEG=88.
- data=0, blank_lz=1 -> only slot 0 shows C0; the other seven slots SEG=FF.
- Change data 12345678 -> 9ABCDEF0 while idx=3 -> the rest of the frame keeps 1234_5678 glyphs. frame_done pulses once after the idx 7->0 tick, and the next frame's slot 0 shows C0 and slot 7 shows 90.
- dp=8'h04, data=FFFF_FFFF -> slot 2 SEG=0E, other slots 8E. With data=0, dp=8'h04, blank_lz=1 -> slot 2 SEG=FF (DP suppressed).
- Assert in_RST asynchronously mid-slot -> AN=FF and SEG=FF in the same cycle, frame_done=0. After release, the first AN=FD appears exactly 4 clk later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for seven-segment front panels.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low segment patterns g..a for hex digits 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + decimal point + blank -> active-low cathode byte.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp_on,
    input  logic       blank,
    output logic [7:0] seg
);

    // A blanked digit goes fully dark, including its decimal point.
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = {~dp_on, hex_glyph(nibble)};
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed common-anode hex display with per-frame snapshot.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        in_RST,
    input  logic [31:0] data,
    input  logic        blank_lz,
    input  logic [7:0]  dp,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (NUM_DIGITS != 8) begin : g_bad_digits
        $error("seg7_scan_display supports exactly 8 digits");
    end
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_div
        $error("seg7_scan_display SCAN_DIV out of range 2..2^20");
    end

    logic [CW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic [2:0]    idx_next;
    logic [31:0]   snap_data_q;
    logic [31:0]   snap_data_nx;
    logic [7:0]    snap_dp_q;
    logic [7:0]    snap_dp_nx;
    logic [7:0]    upper_zero;
    logic          tick;
    logic          latch;
    logic          digit_blank;
    logic [3:0]    nibble;
    logic [7:0]    seg_nx;

    assign tick     = (presc_q == CW'(SCAN_DIV - 1));
    assign idx_next = idx_q + 3'd1;
    assign latch    = tick && (idx_q == 3'd7);

    // Digit 0 of a frame must already see the snapshot taken on the same edge.
    assign snap_data_nx = latch ? data : snap_data_q;
    assign snap_dp_nx   = latch ? dp   : snap_dp_q;

    // Prescaler: wraps every SCAN_DIV cycles, tick on the last count.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CW'(1);
        end
    end

    // Digit index and frame snapshot advance on tick.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            idx_q       <= 3'd0;
            snap_data_q <= 32'd0;
            snap_dp_q   <= 8'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= latch;
            if (tick) begin
                idx_q <= idx_next;
            end
            if (latch) begin
                snap_data_q <= data;
                snap_dp_q   <= dp;
            end
        end
    end

    // upper_zero[i] is set when nibbles i..7 of the upcoming snapshot are all zero.
    always_comb begin
        upper_zero = 8'd0;
        for (int i = 0; i < 8; i++) begin
            upper_zero[i] = ((snap_data_nx >> (4 * i)) == 32'd0);
        end
    end

    assign digit_blank = blank_lz && (idx_next != 3'd0) && upper_zero[idx_next];
    assign nibble      = snap_data_nx[{idx_next, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .dp_on  (snap_dp_nx[idx_next]),
        .blank  (digit_blank),
        .seg    (seg_nx)
    );

    // Registered anode/cathode drive, updated only when the scan advances.
    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            AN  <= AN_OFF;
            SEG <= SEG_OFF;
        end else if (tick) begin
            AN  <= ~(8'd1 << idx_next);
            SEG <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with a tick-count reference model.
module tb_seg7_scan_display;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        in_RST = 1'b1;
    logic [31:0] data = 32'd0;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp = 8'd0;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: clock edges and scan ticks since reset release.
    int          cyc = 0;
    int          ticks = 0;
    logic [31:0] m_snap = 32'd0;
    logic [7:0]  m_dp = 8'd0;
    logic [7:0]  e_an = 8'hFF;
    logic [7:0]  e_seg = 8'hFF;
    logic        e_fd = 1'b0;
    logic [7:0]  glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_scan_display #(.SCAN_DIV(DIV), .NUM_DIGITS(8)) dut (
        .clk        (clk),
        .in_RST     (in_RST),
        .data       (data),
        .blank_lz   (blank_lz),
        .dp         (dp),
        .SEG        (SEG),
        .AN         (AN),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (tick %0d)", tag, obs, exp, ticks);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        ticks  = 0;
        m_snap = 32'd0;
        m_dp   = 8'd0;
        e_an   = 8'hFF;
        e_seg  = 8'hFF;
        e_fd   = 1'b0;
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic step();
        int          d;
        logic [31:0] upper;
        logic        blank;
        @(posedge clk);
        if (in_RST) begin
            cyc++;
            e_fd = 1'b0;
            if (cyc % DIV == 0) begin
                ticks++;
                d = ticks % 8;
                if (d == 0) begin
                    m_snap = data;
                    m_dp   = dp;
                    e_fd   = 1'b1;
                end
                upper = m_snap >> (4 * d);
                blank = blank_lz && (d != 0) && (upper == 32'd0);
                e_an  = ~(8'd1 << d);
                e_seg = blank ? 8'hFF : {~m_dp[d], glyph[upper[3:0]][6:0]};
            end
        end
        #1;
        chk("AN", AN, e_an);
        chk("SEG", SEG, e_seg);
        chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int fd_count;

    initial begin
        // Reset with a value already presented.
        data     = 32'h0000_00A5;
        blank_lz = 1'b0;
        dp       = 8'h00;
        #2 in_RST = 1'b0;
        #1;
        chk("reset_AN", AN, 8'hFF);
        chk("reset_SEG", SEG, 8'hFF);
        chk("reset_fd", {7'd0, frame_done}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 in_RST = 1'b1;
        model_reset();

        // Dark until the first tick, then digit 1 (from the zero reset snapshot).
        run(3);
        chk("pre_tick_AN", AN, 8'hFF);
        step();
        chk("first_AN", AN, 8'hFD);
        chk("first_SEG", SEG, 8'hC0);
        run(2 * 8 * DIV);

        // Leading-zero blanking on A5.
        blank_lz = 1'b1;
        run(2 * 8 * DIV);

        // All-zero value: only digit 0 lit.
        data = 32'd0;
        run(2 * 8 * DIV);

        // Mid-frame data change must not tear the current frame.
        blank_lz = 1'b0;
        data     = 32'h1234_5678;
        run(8 * DIV);
        for (int i = 0; i < 64 && !((ticks % 8 == 3) && (cyc % DIV == 0)); i++) step();
        chk("sync_idx3", AN, 8'hF7);
        data     = 32'h9ABC_DEF0;
        fd_count = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            step();
            if (frame_done) fd_count++;
        end
        chk("fd_once", fd_count[7:0], 8'd1);
        run(8 * DIV);

        // Decimal point on digit 2, then DP suppressed on a blanked digit.
        dp   = 8'h04;
        data = 32'hFFFF_FFFF;
        run(2 * 8 * DIV);
        data     = 32'd0;
        blank_lz = 1'b1;
        run(2 * 8 * DIV);

        // Asynchronous reset mid-slot.
        step();
        #2 in_RST = 1'b0;
        #1;
        chk("async_AN", AN, 8'hFF);
        chk("async_SEG", SEG, 8'hFF);
        chk("async_fd", {7'd0, frame_done}, 8'd0);
        model_reset();
        @(posedge clk);
        #1 in_RST = 1'b1;
        data     = 32'h0000_00A5;
        dp       = 8'h00;
        blank_lz = 1'b0;
        run(3);
        chk("rel_dark_AN", AN, 8'hFF);
        step();
        chk("rel_first_AN", AN, 8'hFD);
        run(8 * DIV);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: data = $urandom;
                    1: data = $urandom >> (4 * $urandom_range(0, 7));
                    2: data = 32'd0;
                    default: data = {28'd0, 4'($urandom)};
                endcase
            end
            if ($urandom_range(0, 15) == 0) dp = 8'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
